// File: rtl/mpe_pkg.sv
// mpe_pkg: shared constants and types for the matrix_pe job scheduler.
//   DW    - neuron/weight beat width
//   AW    - NRAM/WRAM word address width
//   RW    - PE result width
//   state_e - scheduler FSM states
//   cmd_t   - latched job descriptor
package mpe_pkg;

    localparam int unsigned DW = 512;
    localparam int unsigned AW = 16;
    localparam int unsigned RW = 32;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StStream,
        StWaitRes,
        StResult
    } state_e;

    typedef struct packed {
        logic [7:0]    uop;
        logic [AW-1:0] nbase;
        logic [AW-1:0] wbase;
        logic [7:0]    len;
    } cmd_t;

endpackage

// File: rtl/mpe_if.sv
// mpe_if: handshake bundle between the scheduler and matrix_pe.
//   mpe_uop/_valid/_ready       - uop issue handshake
//   mpe_neuron/_valid/_ready    - neuron beat stream
//   mpe_weight/_valid/_ready    - weight beat stream
//   mpe_result, mpe_vld         - single-cycle result pulse, no backpressure
// modport master: scheduler side; modport slave: PE side.
interface mpe_if;
    import mpe_pkg::*;

    logic [7:0]    mpe_uop;
    logic          mpe_uop_valid;
    logic          mpe_uop_ready;
    logic [DW-1:0] mpe_neuron;
    logic          mpe_neuron_valid;
    logic          mpe_neuron_ready;
    logic [DW-1:0] mpe_weight;
    logic          mpe_weight_valid;
    logic          mpe_weight_ready;
    logic [RW-1:0] mpe_result;
    logic          mpe_vld;

    modport master (
        output mpe_uop, mpe_uop_valid,
        input  mpe_uop_ready,
        output mpe_neuron, mpe_neuron_valid,
        input  mpe_neuron_ready,
        output mpe_weight, mpe_weight_valid,
        input  mpe_weight_ready,
        input  mpe_result, mpe_vld
    );

    modport slave (
        input  mpe_uop, mpe_uop_valid,
        output mpe_uop_ready,
        input  mpe_neuron, mpe_neuron_valid,
        output mpe_neuron_ready,
        input  mpe_weight, mpe_weight_valid,
        output mpe_weight_ready,
        output mpe_result, mpe_vld
    );

endinterface

// File: rtl/mpe_stream_fetch.sv
// mpe_stream_fetch: one fetch lane. Generates base+issued read addresses into a
// 1-cycle-latency RAM, tracks the read in flight and buffers data in a 2-entry FIFO
// whose head is presented on a valid/ready beat output.
//   clk, rst_n          - clock, asynchronous active-low reset
//   clear               - restart the lane for a new job (counters and FIFO emptied)
//   active              - reads may be issued
//   base, len           - first address and beat count of the job
//   rd_en, rd_addr      - RAM read request
//   rd_data             - RAM read data, valid the cycle after rd_en
//   beat, beat_valid, beat_ready - FIFO head handshake
//   done                - every beat of the job has been accepted
module mpe_stream_fetch #(
    parameter int unsigned DW = 512,
    parameter int unsigned AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          active,
    input  logic [AW-1:0] base,
    input  logic [7:0]    len,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] beat,
    output logic          beat_valid,
    input  logic          beat_ready,
    output logic          done
);

    logic [7:0]    issued_q;
    logic [7:0]    accepted_q;
    logic          inflight_q;
    logic [1:0]    count_q;
    logic          wptr_q;
    logic          rptr_q;
    logic [DW-1:0] mem_q [2];

    logic       pop;
    logic       push;
    logic [2:0] occ;

    assign beat_valid = (count_q != 2'd0);
    assign beat       = mem_q[rptr_q];
    assign pop        = beat_valid && beat_ready;
    assign push       = inflight_q;

    // A slot freed by this cycle's pop is reusable at once; without this credit the
    // lane could only sustain two beats every three cycles.
    assign occ     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_en   = active && (issued_q < len) && (occ < 3'd2);
    assign rd_addr = base + AW'(issued_q);
    assign done    = (accepted_q == len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
        end else if (clear) begin
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
        end else begin
            inflight_q <= rd_en;
            if (rd_en) issued_q <= issued_q + 8'd1;
            if (pop) begin
                accepted_q <= accepted_q + 8'd1;
                rptr_q     <= ~rptr_q;
            end
            if (push) begin
                mem_q[wptr_q] <= rd_data;
                wptr_q        <= ~wptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/mpe_sched.sv
// mpe_sched: sequences one matrix_pe dot-product job per command.
//   clk, rst_n                       - clock, asynchronous active-low reset
//   cmd_valid/ready, cmd_uop, cmd_nbase, cmd_wbase, cmd_len - job descriptor handshake
//   nram_rd_en/addr/data, wram_rd_en/addr/data - synchronous RAM read ports
//   pe                               - PE handshake bundle (master side)
//   res_data, res_valid, res_ready   - result handshake
//   busy      - a job is in progress
//   err_len   - one-cycle pulse when a len=0 command is accepted
//   err_spur  - sticky: a PE result pulse arrived while no result was expected
module mpe_sched
    import mpe_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [7:0]    cmd_uop,
    input  logic [AW-1:0] cmd_nbase,
    input  logic [AW-1:0] cmd_wbase,
    input  logic [7:0]    cmd_len,
    output logic          nram_rd_en,
    output logic [AW-1:0] nram_rd_addr,
    input  logic [DW-1:0] nram_rd_data,
    output logic          wram_rd_en,
    output logic [AW-1:0] wram_rd_addr,
    input  logic [DW-1:0] wram_rd_data,
    mpe_if.master         pe,
    output logic [RW-1:0] res_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          busy,
    output logic          err_len,
    output logic          err_spur
);

    state_e        state_q, state_d;
    cmd_t          cmd_q;
    logic [RW-1:0] res_q;
    logic          err_len_q;
    logic          err_spur_q;

    logic cmd_fire;
    logic capture;
    logic spur;
    logic n_done, w_done;
    logic streaming;

    assign cmd_fire  = cmd_valid && (state_q == StIdle);
    assign streaming = (state_q == StStream);

    mpe_stream_fetch #(.DW(DW), .AW(AW)) u_nfetch (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (cmd_fire),
        .active     (streaming),
        .base       (cmd_q.nbase),
        .len        (cmd_q.len),
        .rd_en      (nram_rd_en),
        .rd_addr    (nram_rd_addr),
        .rd_data    (nram_rd_data),
        .beat       (pe.mpe_neuron),
        .beat_valid (pe.mpe_neuron_valid),
        .beat_ready (pe.mpe_neuron_ready),
        .done       (n_done)
    );

    mpe_stream_fetch #(.DW(DW), .AW(AW)) u_wfetch (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (cmd_fire),
        .active     (streaming),
        .base       (cmd_q.wbase),
        .len        (cmd_q.len),
        .rd_en      (wram_rd_en),
        .rd_addr    (wram_rd_addr),
        .rd_data    (wram_rd_data),
        .beat       (pe.mpe_weight),
        .beat_valid (pe.mpe_weight_valid),
        .beat_ready (pe.mpe_weight_ready),
        .done       (w_done)
    );

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle:   if (cmd_fire && (cmd_len != 8'd0)) state_d = StIssue;
            StIssue:  if (pe.mpe_uop_ready) state_d = StStream;
            StStream: begin
                if (n_done && w_done) begin
                    // A zero-latency PE can answer in the last stream cycle.
                    if (pe.mpe_vld) begin
                        capture = 1'b1;
                        state_d = StResult;
                    end else begin
                        state_d = StWaitRes;
                    end
                end
            end
            StWaitRes: begin
                if (pe.mpe_vld) begin
                    capture = 1'b1;
                    state_d = StResult;
                end
            end
            StResult: if (res_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        spur = pe.mpe_vld && !capture;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cmd_q      <= '0;
            res_q      <= '0;
            err_len_q  <= 1'b0;
            err_spur_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_len_q <= cmd_fire && (cmd_len == 8'd0);
            if (cmd_fire) cmd_q <= '{uop: cmd_uop, nbase: cmd_nbase, wbase: cmd_wbase,
                                     len: cmd_len};
            if (capture) res_q <= pe.mpe_result;
            if (spur) err_spur_q <= 1'b1;
        end
    end

    assign cmd_ready        = (state_q == StIdle);
    assign busy             = (state_q != StIdle);
    assign pe.mpe_uop       = cmd_q.uop;
    assign pe.mpe_uop_valid = (state_q == StIssue);
    assign res_data         = res_q;
    assign res_valid        = (state_q == StResult);
    assign err_len          = err_len_q;
    assign err_spur         = err_spur_q;

endmodule

// File: tb/tb_mpe_sched.sv
// tb_mpe_sched: directed self-checking bench for mpe_sched with RAM and PE models.
module tb_mpe_sched;
    import mpe_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [7:0]    cmd_uop = '0;
    logic [AW-1:0] cmd_nbase = '0;
    logic [AW-1:0] cmd_wbase = '0;
    logic [7:0]    cmd_len = '0;
    logic          nram_rd_en, wram_rd_en;
    logic [AW-1:0] nram_rd_addr, wram_rd_addr;
    logic [DW-1:0] nram_rd_data = '0;
    logic [DW-1:0] wram_rd_data = '0;
    logic [RW-1:0] res_data;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic          busy, err_len, err_spur;

    mpe_if pe_bus ();

    mpe_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_uop      (cmd_uop),
        .cmd_nbase    (cmd_nbase),
        .cmd_wbase    (cmd_wbase),
        .cmd_len      (cmd_len),
        .nram_rd_en   (nram_rd_en),
        .nram_rd_addr (nram_rd_addr),
        .nram_rd_data (nram_rd_data),
        .wram_rd_en   (wram_rd_en),
        .wram_rd_addr (wram_rd_addr),
        .wram_rd_data (wram_rd_data),
        .pe           (pe_bus),
        .res_data     (res_data),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .busy         (busy),
        .err_len      (err_len),
        .err_spur     (err_spur)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] nword(input logic [15:0] a);
        return {16{16'hA5A5, a}};
    endfunction

    function automatic logic [DW-1:0] wword(input logic [15:0] a);
        return {16{16'h5A5A, a ^ 16'h00FF}};
    endfunction

    // RAM models: 1-cycle read latency.
    always @(posedge clk) begin
        if (nram_rd_en) nram_rd_data <= nword(nram_rd_addr);
        if (wram_rd_en) wram_rd_data <= wword(wram_rd_addr);
    end

    // Monitor: sampled mid-cycle; per-job counters restart at each command handshake.
    int            n_cnt, w_cnt, n_rd, w_rd, n_bad, w_bad, na_bad, wa_bad, withdraw;
    logic [15:0]   job_nb, job_wb, n_first, n_last;
    logic          p_nv, p_nr, p_wv, p_wr, p_uv, p_ur, p_rv, p_rr;
    logic [DW-1:0] p_n, p_w;
    logic [7:0]    p_u;
    logic [RW-1:0] p_rd;

    initial begin
        n_cnt = 0; w_cnt = 0; n_rd = 0; w_rd = 0; n_bad = 0; w_bad = 0;
        na_bad = 0; wa_bad = 0; withdraw = 0;
        job_nb = '0; job_wb = '0; n_first = '0; n_last = '0;
        p_nv = 0; p_nr = 0; p_wv = 0; p_wr = 0; p_uv = 0; p_ur = 0; p_rv = 0; p_rr = 0;
        p_n = '0; p_w = '0; p_u = '0; p_rd = '0;
    end

    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) begin
            n_cnt = 0; w_cnt = 0; n_rd = 0; w_rd = 0;
            n_bad = 0; w_bad = 0; na_bad = 0; wa_bad = 0;
            job_nb = cmd_nbase; job_wb = cmd_wbase;
        end else begin
            if (nram_rd_en) begin
                if (nram_rd_addr !== 16'(job_nb + n_rd)) na_bad++;
                if (n_rd == 0) n_first = nram_rd_addr;
                n_last = nram_rd_addr;
                n_rd++;
            end
            if (wram_rd_en) begin
                if (wram_rd_addr !== 16'(job_wb + w_rd)) wa_bad++;
                w_rd++;
            end
            if (pe_bus.mpe_neuron_valid && pe_bus.mpe_neuron_ready) begin
                if (pe_bus.mpe_neuron !== nword(16'(job_nb + n_cnt))) n_bad++;
                n_cnt++;
            end
            if (pe_bus.mpe_weight_valid && pe_bus.mpe_weight_ready) begin
                if (pe_bus.mpe_weight !== wword(16'(job_wb + w_cnt))) w_bad++;
                w_cnt++;
            end
        end
        if (!rst_n) begin
            p_nv = 0; p_wv = 0; p_uv = 0; p_rv = 0;
        end else begin
            if (p_nv && !p_nr && (!pe_bus.mpe_neuron_valid || pe_bus.mpe_neuron !== p_n))
                withdraw++;
            if (p_wv && !p_wr && (!pe_bus.mpe_weight_valid || pe_bus.mpe_weight !== p_w))
                withdraw++;
            if (p_uv && !p_ur && (!pe_bus.mpe_uop_valid || pe_bus.mpe_uop !== p_u))
                withdraw++;
            if (p_rv && !p_rr && (!res_valid || res_data !== p_rd))
                withdraw++;
            p_nv = pe_bus.mpe_neuron_valid; p_nr = pe_bus.mpe_neuron_ready;
            p_n  = pe_bus.mpe_neuron;
            p_wv = pe_bus.mpe_weight_valid; p_wr = pe_bus.mpe_weight_ready;
            p_w  = pe_bus.mpe_weight;
            p_uv = pe_bus.mpe_uop_valid; p_ur = pe_bus.mpe_uop_ready; p_u = pe_bus.mpe_uop;
            p_rv = res_valid; p_rr = res_ready; p_rd = res_data;
        end
    end

    int checks = 0;
    int failures = 0;
    bit rand_mode = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            pe_bus.mpe_uop_ready    = 1'($urandom_range(0, 1));
            pe_bus.mpe_neuron_ready = 1'($urandom_range(0, 1));
            pe_bus.mpe_weight_ready = 1'($urandom_range(0, 1));
        end else begin
            pe_bus.mpe_uop_ready    = 1'b1;
            pe_bus.mpe_neuron_ready = 1'b1;
            pe_bus.mpe_weight_ready = 1'b1;
        end
    endtask

    task automatic start_cmd(input logic [7:0] uop, input logic [15:0] nb, input logic [15:0] wb,
                             input logic [7:0] len);
        cmd_valid = 1'b1; cmd_uop = uop; cmd_nbase = nb; cmd_wbase = wb; cmd_len = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Runs a whole job; stream_ticks must equal exp_ticks unless exp_ticks is 0.
    task automatic run_job(input string tag, input logic [7:0] uop, input logic [15:0] nb,
                           input logic [15:0] wb, input logic [7:0] len,
                           input logic [31:0] res, input bit slow, input int exp_ticks);
        int t;
        bit saw_ready;
        bit bad_hold;
        start_cmd(uop, nb, wb, len);
        chk({tag, "_uop_valid"}, 64'(pe_bus.mpe_uop_valid), 64'd1);
        chk({tag, "_uop"}, 64'(pe_bus.mpe_uop), 64'(uop));
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        t = 0;
        saw_ready = 1'b0;
        while ((n_cnt < int'(len) || w_cnt < int'(len)) && t < 3000) begin
            tick();
            t++;
            if (cmd_ready) saw_ready = 1'b1;
        end
        chk({tag, "_stream_in_budget"}, 64'(t < 3000), 64'd1);
        if (exp_ticks != 0) chk({tag, "_stream_ticks"}, 64'(t), 64'(exp_ticks));
        pe_bus.mpe_vld = 1'b1;
        pe_bus.mpe_result = res;
        tick();
        pe_bus.mpe_vld = 1'b0;
        pe_bus.mpe_result = '0;
        chk({tag, "_res_valid"}, 64'(res_valid), 64'd1);
        chk({tag, "_res_data"}, 64'(res_data), 64'(res));
        if (slow) begin
            bad_hold = 1'b0;
            repeat (5) begin
                tick();
                if (!res_valid || res_data !== res || cmd_ready) bad_hold = 1'b1;
            end
            chk({tag, "_res_hold"}, 64'(bad_hold), 64'd0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_res_released"}, 64'(res_valid), 64'd0);
        chk({tag, "_idle_again"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_cmd_ready_held_low"}, 64'(saw_ready), 64'd0);
        chk({tag, "_n_beats"}, 64'(n_cnt), 64'(len));
        chk({tag, "_w_beats"}, 64'(w_cnt), 64'(len));
        chk({tag, "_n_reads"}, 64'(n_rd), 64'(len));
        chk({tag, "_w_reads"}, 64'(w_rd), 64'(len));
        chk({tag, "_n_addr_seq"}, 64'(na_bad), 64'd0);
        chk({tag, "_w_addr_seq"}, 64'(wa_bad), 64'd0);
        chk({tag, "_n_data_order"}, 64'(n_bad), 64'd0);
        chk({tag, "_w_data_order"}, 64'(w_bad), 64'd0);
    endtask

    initial begin
        int t;
        bit saw_uv;
        pe_bus.mpe_uop_ready = 1'b1;
        pe_bus.mpe_neuron_ready = 1'b1;
        pe_bus.mpe_weight_ready = 1'b1;
        pe_bus.mpe_result = '0;
        pe_bus.mpe_vld = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) tick();

        // Reset state.
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_uop_valid", 64'(pe_bus.mpe_uop_valid), 64'd0);
        chk("rst_uop", 64'(pe_bus.mpe_uop), 64'd0);
        chk("rst_n_valid", 64'(pe_bus.mpe_neuron_valid), 64'd0);
        chk("rst_rd_en", 64'({nram_rd_en, wram_rd_en}), 64'd0);
        chk("rst_addrs", 64'({nram_rd_addr, wram_rd_addr}), 64'd0);
        chk("rst_res", 64'({res_valid, res_data}), 64'd0);
        chk("rst_errs", 64'({err_len, err_spur}), 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: back-to-back streaming; beats accepted on edges t+4..t+L+3.
        run_job("t1", 8'h11, 16'h0000, 16'h0100, 8'd35, 32'hCAFE_0011, 1'b0, 38);

        // 2: random PE backpressure and a slow result consumer.
        rand_mode = 1'b1;
        run_job("t2", 8'h11, 16'h0000, 16'h0100, 8'd35, 32'hCAFE_0011, 1'b1, 0);
        rand_mode = 1'b0;
        tick();
        chk("t2_no_spur", 64'(err_spur), 64'd0);

        // 3: len=0 command is rejected with a pulse.
        start_cmd(8'h22, 16'h0040, 16'h0080, 8'd0);
        chk("t3_err_len_pulse", 64'(err_len), 64'd1);
        chk("t3_still_idle", 64'({cmd_ready, busy}), 64'b10);
        saw_uv = 1'b0;
        repeat (3) begin
            tick();
            if (pe_bus.mpe_uop_valid || busy) saw_uv = 1'b1;
        end
        chk("t3_err_len_dropped", 64'(err_len), 64'd0);
        chk("t3_no_activity", 64'(saw_uv), 64'd0);
        chk("t3_no_reads", 64'(n_rd + w_rd), 64'd0);

        // 4: NRAM address wraps at the top of the address space.
        run_job("t4", 8'h33, 16'hFFFE, 16'h0200, 8'd4, 32'h1234_5678, 1'b0, 7);
        chk("t4_first_addr", 64'(n_first), 64'hFFFE);
        chk("t4_last_addr", 64'(n_last), 64'h0001);

        // 5: reset mid-job, then a fresh job.
        start_cmd(8'h44, 16'h0300, 16'h0400, 8'd35);
        t = 0;
        while (n_cnt < 10 && t < 200) begin
            tick();
            t++;
        end
        chk("t5_reach_10_beats", 64'(t < 200), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_valids", 64'({pe_bus.mpe_uop_valid, pe_bus.mpe_neuron_valid,
                              pe_bus.mpe_weight_valid, res_valid}), 64'd0);
        chk("t5_rd_en", 64'({nram_rd_en, wram_rd_en}), 64'd0);
        chk("t5_addrs", 64'({nram_rd_addr, wram_rd_addr}), 64'd0);
        chk("t5_res_data", 64'(res_data), 64'd0);
        chk("t5_uop", 64'(pe_bus.mpe_uop), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_job("t5b", 8'h55, 16'h0010, 16'h0020, 8'd4, 32'h0BAD_F00D, 1'b0, 7);

        // 6: spurious result pulse in IDLE.
        pe_bus.mpe_vld = 1'b1;
        pe_bus.mpe_result = 32'hDEAD_BEEF;
        tick();
        pe_bus.mpe_vld = 1'b0;
        chk("t6_err_spur_set", 64'(err_spur), 64'd1);
        chk("t6_no_res_valid", 64'(res_valid), 64'd0);
        repeat (3) tick();
        chk("t6_err_spur_sticky", 64'(err_spur), 64'd1);
        chk("t6_still_idle", 64'({res_valid, cmd_ready}), 64'b01);

        chk("valid_never_withdrawn", 64'(withdraw), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
